mem_ctrl_param: RTL and testbench

Parametrised single-port memory with a ready/response handshake, per-byte write enables, configurable read latency and error reporting for illegal requests. It replaces the fixed 16×32 memory behind the testbench memory interface. The bench drives requests through the interface; the block answers each accepted request with exactly one `response` pulse.

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_array.sv | 40 ++++
 rtl/mem_ctrl_param.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_ctrl_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for the parametrised memory controller.
// Optional feature macro used by the controller: MEM_INIT_CLEAR_EN.
package mem_ctrl_pkg;

  // Controller states. ST_INIT is only ever entered when MEM_INIT_CLEAR_EN is defined.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  // Largest supported read latency and the down-counter width that covers it.
  localparam int MAX_RD_LATENCY = 8;
  localparam int CNT_W          = $clog2(MAX_RD_LATENCY);

  // A request is illegal when it targets a word outside the populated range
  // or asks for a read and a write at the same time.
  function automatic logic req_is_error(input logic        wr,
                                        input logic        rd,
                                        input logic [31:0] addr,
                                        input int unsigned mem_size);
    return (wr & rd) | (addr >= mem_size);
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word storage with per-byte write enables and a
// registered read port, written so synthesis can map it onto block RAM.
// Contents have no reset.
module mem_array #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // Byte-granular write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Registered read, sampled only when a legal read is accepted.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/mem_ctrl_param.sv
// mem_ctrl_param: single-port memory with ready/response handshake, byte
// enables, configurable read latency and error reporting.
// Optional feature: define MEM_INIT_CLEAR_EN to sweep zeros into the array
// after every reset release before the first request is accepted.
module mem_ctrl_param
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    response,
  output logic                    error
);

  localparam int BE_W = DATA_WIDTH / 8;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_rd_q;     // accepted request is a legal read
  logic               req_err_q;    // accepted request is illegal
  logic               response_q;
  logic               error_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic               accept;
  logic               req_err;
  logic               legal_wr;
  logic               legal_rd;
  logic [CNT_W-1:0]   lat_m1;
  logic               done;

  logic                  arr_we;
  logic                  arr_re;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [BE_W-1:0]       arr_be;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic [DATA_WIDTH-1:0] rd_pipe_out;

  // Request decode: a request is taken only in IDLE; combined wr&rd and
  // out-of-range addresses are classified as errors and never touch the array.
  always_comb begin
    accept   = (state_q == ST_IDLE) & (wr | rd);
    req_err  = req_is_error(wr, rd, 32'(addr), MEM_SIZE);
    legal_wr = accept & wr & ~req_err;
    legal_rd = accept & rd & ~req_err;
    lat_m1   = (rd & ~wr) ? CNT_W'(RD_LATENCY - 1) : '0;
    done     = (state_q == ST_BUSY) & (cnt_q == '0);
  end

  // ready is also gated by reset so it reads low for the whole reset period.
  assign ready    = (state_q == ST_IDLE) & reset;
  assign response = response_q;
  assign error    = error_q;
  assign rdata    = rdata_q;

`ifdef MEM_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic                  init_last;

  assign init_last = (init_addr_q == ADDR_WIDTH'(MEM_SIZE - 1));

  // Sweep address for the post-reset clear; restarts at 0 on every reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_addr_q <= '0;
    end else begin
      init_addr_q <= init_addr_d;
    end
  end

  // Advance the sweep one word per cycle while in INIT.
  always_comb begin
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT && !init_last) begin
      init_addr_d = init_addr_q + 1'b1;
    end
  end

  // Array port mux: the clear sweep owns the write port while in INIT.
  always_comb begin
    arr_we    = legal_wr;
    arr_re    = legal_rd;
    arr_addr  = addr;
    arr_wdata = wdata;
    arr_be    = be;
    if (state_q == ST_INIT) begin
      arr_we    = 1'b1;
      arr_re    = 1'b0;
      arr_addr  = init_addr_q;
      arr_wdata = '0;
      arr_be    = '1;
    end
  end
`else
  // Array port driven straight from the accepted request.
  always_comb begin
    arr_we    = legal_wr;
    arr_re    = legal_rd;
    arr_addr  = addr;
    arr_wdata = wdata;
    arr_be    = be;
  end
`endif

  // State and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
`ifdef MEM_INIT_CLEAR_EN
      state_q <= ST_INIT;
`else
      state_q <= ST_IDLE;
`endif
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the counter is loaded only on accept from IDLE, so it
  // can never wrap while BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = lat_m1;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
`ifdef MEM_INIT_CLEAR_EN
        if (init_last) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture request type and error status at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_rd_q  <= 1'b0;
      req_err_q <= 1'b0;
    end else if (accept) begin
      req_rd_q  <= legal_rd;
      req_err_q <= req_err;
    end
  end

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_mem_array (
    .clk     (clk),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .rdata_o (arr_rdata)
  );

  // Read data path: the array output register is the first stage, and
  // RD_LATENCY-1 further stages bring the word up to the response edge.
  if (RD_LATENCY == 1) begin : g_no_pipe
    assign rd_pipe_out = arr_rdata;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] stage_q [RD_LATENCY-1];

    // Shift the sampled word one stage per cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < RD_LATENCY - 1; k++) begin
          stage_q[k] <= '0;
        end
      end else begin
        stage_q[0] <= arr_rdata;
        for (int k = 1; k < RD_LATENCY - 1; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
    end

    assign rd_pipe_out = stage_q[RD_LATENCY-2];
  end

  // Response registers: pulse on completion; rdata/error update only then
  // and hold until the next response. A legal write leaves rdata untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      response_q <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      response_q <= done;
      if (done) begin
        error_q <= req_err_q;
        if (req_err_q) begin
          rdata_q <= '0;
        end else if (req_rd_q) begin
          rdata_q <= rd_pipe_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl_param.sv
// tb_mem_ctrl_param: directed, table-driven bench for mem_ctrl_param
// (MEM_SIZE=12, RD_LATENCY=2), plus hand sequences for held requests and
// mid-operation reset. Honours MEM_INIT_CLEAR_EN when defined.
module tb_mem_ctrl_param;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MS = 12;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr, rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic          ready, response, error;
  logic [DW-1:0] rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl_param #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_SIZE   (MS),
    .RD_LATENCY (RL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .ready    (ready),
    .rdata    (rdata),
    .response (response),
    .error    (error)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
    int          lat;
    logic        err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One request: wait for ready, present for one edge, measure latency.
  task automatic do_req(input string name, input logic w, input logic r,
                        input logic [3:0] a, input logic [31:0] d, input logic [3:0] b,
                        input int exp_lat, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd);
    int n;
    bit got;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "/ready_before"}, 32'(ready), 32'd1);
    wr = w; rd = r; addr = a; wdata = d; be = b;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    chk({name, "/ready_fall"}, 32'(ready), 32'd0);
    n = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (response) got = 1'b1;
    end
    chk({name, "/latency"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
    if (got) begin
      chk({name, "/error"}, 32'(error), 32'(exp_err));
      if (chk_rd) chk({name, "/rdata"}, rdata, exp_rd);
      chk({name, "/ready_rise"}, 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      chk({name, "/resp_fall"}, 32'(response), 32'd0);
    end
    $display("txn %s wr=%0b rd=%0b addr=%0d wdata=0x%08h be=%h -> lat=%0d err=%0b rdata=0x%08h",
             name, w, r, a, d, b, n, error, rdata);
  endtask

  // Release reset on a falling edge and check how long ready stays low.
  task automatic release_reset(input string name);
    int n;
    @(negedge clk);
    reset = 1'b1;
    #1;
`ifdef MEM_INIT_CLEAR_EN
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({name, "/init_cycles"}, 32'(n), 32'(MS));
`else
    n = 0;
    chk({name, "/ready_first_cycle"}, 32'(ready), 32'd1);
`endif
  endtask

  vec_t vecs[17];

  initial begin
    int resp_cnt;
    logic [31:0] exp_after;

    vecs[0]  = '{1'b1, 1'b0, 4'd3,  32'hDEADBEEF, 4'hF, 1,  1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3,  32'h0,        4'h0, RL, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 4'd3,  32'h11223344, 4'h5, 1,  1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 4'd3,  32'h0,        4'h0, RL, 1'b0, 1'b1, 32'hDE22BE44};
    vecs[4]  = '{1'b0, 1'b1, 4'd13, 32'h0,        4'h0, RL, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 4'd1,  32'hCAFEF00D, 4'hF, 1,  1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 4'd1,  32'h0,        4'h0, RL, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, 1'b0, 4'd2,  32'hA5A5A5A5, 4'hF, 1,  1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 4'd2,  32'hFFFFFFFF, 4'hF, 1,  1'b1, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 4'd2,  32'h0,        4'h0, RL, 1'b0, 1'b1, 32'hA5A5A5A5};
    vecs[10] = '{1'b1, 1'b0, 4'd2,  32'hFFFFFFFF, 4'h0, 1,  1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 4'd2,  32'h0,        4'h0, RL, 1'b0, 1'b1, 32'hA5A5A5A5};
    vecs[12] = '{1'b1, 1'b0, 4'd12, 32'h77777777, 4'hF, 1,  1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 4'd11, 32'h0BADF00D, 4'hF, 1,  1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 4'd11, 32'h0,        4'h0, RL, 1'b0, 1'b1, 32'h0BADF00D};
    vecs[15] = '{1'b0, 1'b1, 4'd12, 32'h0,        4'h0, RL, 1'b1, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 1'b1, 4'd1,  32'h0,        4'h0, RL, 1'b0, 1'b1, 32'hCAFEF00D};

    reset = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; be = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset/ready", 32'(ready), 32'd0);
    chk("reset/response", 32'(response), 32'd0);
    chk("reset/error", 32'(error), 32'd0);
    chk("reset/rdata", rdata, 32'd0);
    release_reset("rel0");

    foreach (vecs[i]) begin
      do_req($sformatf("v%0d", i), vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].b,
             vecs[i].lat, vecs[i].err, vecs[i].chk_rd, vecs[i].exp_rd);
    end

    // Read addr 1, then hold a write to addr 1 while ready is low.
    @(negedge clk);
    rd = 1'b1; addr = 4'd1;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b1; wdata = 32'h12345678; be = 4'hF;
    resp_cnt = 0;
    for (int k = 0; k < RL; k++) begin
      @(posedge clk);
      #1;
      if (response) resp_cnt++;
    end
    chk("held/one_response", 32'(resp_cnt), 32'd1);
    chk("held/rdata_old", rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    wr = 1'b0;
    chk("held/accepted", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("held/wr_response", 32'(response), 32'd1);
    $display("txn held_write addr=1 responses_in_read_window=%0d", resp_cnt);
    do_req("held_rdback", 1'b0, 1'b1, 4'd1, 32'h0, 4'h0, RL, 1'b0, 1'b1, 32'h12345678);

    // Write accepted, then reset before its response edge.
    @(negedge clk);
    wr = 1'b1; addr = 4'd5; wdata = 32'h55AA55AA; be = 4'hF;
    @(posedge clk);
    #1;
    wr = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_wr/response", 32'(response), 32'd0);
    chk("rst_wr/ready", 32'(ready), 32'd0);
    chk("rst_wr/rdata", rdata, 32'd0);
    chk("rst_wr/error", 32'(error), 32'd0);
    $display("txn reset_during_write addr=5");
    release_reset("rel1");

    // Read accepted, reset one cycle later: the response must never appear.
    @(negedge clk);
    rd = 1'b1; addr = 4'd5;
    @(posedge clk);
    #1;
    rd = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    resp_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (response) resp_cnt++;
    end
    release_reset("rel2");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (response) resp_cnt++;
    end
    chk("rst_rd/no_response", 32'(resp_cnt), 32'd0);
    $display("txn reset_during_read addr=5 responses=%0d", resp_cnt);

`ifdef MEM_INIT_CLEAR_EN
    exp_after = 32'h0;
`else
    exp_after = 32'h55AA55AA;
`endif
    do_req("after_reset_rd5", 1'b0, 1'b1, 4'd5, 32'h0, 4'h0, RL, 1'b0, 1'b1, exp_after);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
